watch_display: RTL and testbench
================================

WATCH_DISPLAY -- requirements
Module: watch_display

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000: clock cycles per digit slot, legal range 2..65535.
REQ-002 The block SHALL have parameter BLINK_DIV, default 64: frames per blink half-period, legal range 1..255.
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 1: when 1, seg, dp and an are driven active-low; when 0, active-high.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 sec_lsb, sec_msb, min_lsb, min_msb, hr_lsb, hr_msb  in  4 each  BCD time digits from the time-keeping stage.
REQ-007 blink_en  in  6  per-digit blink mask; bit i pairs with digit slot i.
REQ-008 seg  out  7  segment lines; bit 0 = a through bit 6 = g.
REQ-009 dp  out  1  decimal-point line.
REQ-010 an  out  6  digit-enable lines; bit i enables digit slot i.
REQ-011 frame_done  out  1  one-cycle pulse marking the end of a full six-digit scan.

Function
REQ-012 Slot map SHALL be: 0=sec_lsb, 1=sec_msb, 2=min_lsb, 3=min_msb, 4=hr_lsb, 5=hr_msb.
REQ-013 A scan counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap, the slot index SHALL advance by 1, with 5 -> 0.
REQ-014 The six inputs SHALL be captured into a shadow register on the cycle the slot index wraps 5 -> 0, and on the first clock after rst_n deasserts; displayed digits SHALL come only from the shadow, so no frame mixes old and new time.
REQ-015 Ghost blanking: while the scan counter is 0, all an lines SHALL be inactive; during counts 1..SCAN_DIV-1, exactly one an line (the current slot) SHALL be active.
REQ-016 seg, dp and an SHALL be registered; they SHALL reflect the slot index and scan count of the previous cycle (1-cycle latency).
REQ-017 Decode: values 0-9 SHALL map to the standard 7-segment glyphs (for example, 0 = a..f lit and g dark; 1 = b,c lit).
REQ-018 Values 10-15 SHALL display a dash (g only lit).
REQ-019 Leading-zero blank: slot 5 with a shadow value of 0 SHALL show all segments dark, with the an line still active.
REQ-020 Blink phase SHALL toggle every BLINK_DIV completed frames; while the phase is 1, any slot whose blink_en bit is set SHALL show all segments and dp dark.
REQ-021 blink_en SHALL be sampled live, not shadowed.
REQ-022 dp SHALL be active on slots 2 and 4 only, unless that slot is blanked by blink.
REQ-023 frame_done SHALL pulse high for exactly one cycle, coincident with the shadow capture on the 5 -> 0 wrap; it SHALL NOT pulse for the post-reset capture.
REQ-024 The frame counter SHALL be ceil(log2(BLINK_DIV+1)) bits wide, reset to 0, and cleared when it reaches BLINK_DIV.
REQ-025 The scan counter SHALL be 16 bits; no arithmetic overflow SHALL be possible within the legal parameter ranges.

Reset
REQ-026 While rst_n is low, the block SHALL hold: scan counter 0, slot index 0, shadow 0, blink phase 0, frame counter 0, frame_done 0, all an/seg/dp at inactive level.
REQ-027 Reset asserted mid-frame SHALL take effect immediately; the first active an after release SHALL be slot 0, two cycles after release.

Structure
REQ-028 A shared package watch_pkg SHALL hold the slot-index constants, the glyph constants (digits 0-9, dash, blank) and the digit-count constant 6.
REQ-029 A combinational sub-module bcd_to_seg (4-bit in, 7-bit active-high out, dash for values above 9) SHALL perform decoding; the active-low inversion SHALL be applied in watch_display.

Verification (SCAN_DIV=4, BLINK_DIV=2, ACTIVE_LOW=0)
REQ-030 Inputs 12:34:56, blink_en=0 -> per frame, an sequence 000000,000001x3, 000000,000010x3 ... through 100000; seg glyphs 6,5,4,3,2,1; dp on slots 2 and 4; frame_done every 24 cycles.
REQ-031 Change sec_lsb 6 -> 7 mid-frame -> current frame still shows 6; next frame shows 7.
REQ-032 hr_msb=0 -> slot 5 seg=0000000 with an[5] active; hr_lsb=12 -> slot 4 seg=1000000 (dash).
REQ-033 blink_en=000011 -> slots 0-1 visible for frames 0-1, dark for frames 2-3, repeating; other slots unaffected.
REQ-034 Assert rst_n low during slot 3, then release -> outputs inactive immediately; first active an=000001 two cycles after release; no frame_done until the first full frame completes.

Source files
------------

// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared constants for the six-digit watch display
package watch_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [2:0] SLOT_SEC_LSB = 3'd0;
  localparam logic [2:0] SLOT_SEC_MSB = 3'd1;
  localparam logic [2:0] SLOT_MIN_LSB = 3'd2;
  localparam logic [2:0] SLOT_MIN_MSB = 3'd3;
  localparam logic [2:0] SLOT_HR_LSB  = 3'd4;
  localparam logic [2:0] SLOT_HR_MSB  = 3'd5;

  // Active-high glyphs, bit 0 = segment a ... bit 6 = segment g
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - BCD digit to active-high seven-segment glyph
module bcd_to_seg
  import watch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Values above 9 are not legal BCD and show a dash
  always_comb begin
    seg = GLYPH_DASH;
    case (bcd)
      4'd0:    seg = GLYPH_0;
      4'd1:    seg = GLYPH_1;
      4'd2:    seg = GLYPH_2;
      4'd3:    seg = GLYPH_3;
      4'd4:    seg = GLYPH_4;
      4'd5:    seg = GLYPH_5;
      4'd6:    seg = GLYPH_6;
      4'd7:    seg = GLYPH_7;
      4'd8:    seg = GLYPH_8;
      4'd9:    seg = GLYPH_9;
      default: seg = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/watch_display.sv
// rtl/watch_display.sv - multiplexed six-digit seven-segment watch display driver
module watch_display
  import watch_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned BLINK_DIV  = 64,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sec_lsb,
  input  logic [3:0] sec_msb,
  input  logic [3:0] min_lsb,
  input  logic [3:0] min_msb,
  input  logic [3:0] hr_lsb,
  input  logic [3:0] hr_msb,
  input  logic [5:0] blink_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       frame_done
);

  localparam int          FW        = $clog2(BLINK_DIV + 1);
  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_END = FW'(BLINK_DIV);
  localparam logic        POL       = (ACTIVE_LOW != 0);

  logic [15:0]   scan_cnt;
  logic [2:0]    slot;
  logic [3:0]    shadow [NUM_DIGITS];
  logic          init_pend;
  logic          blink_phase;
  logic [FW-1:0] frame_cnt;
  logic [FW-1:0] frame_next;

  logic          scan_wrap;
  logic          frame_wrap;
  logic [5:0]    slot_onehot;
  logic [3:0]    cur_digit;
  logic [6:0]    glyph;
  logic          blink_hit;
  logic          lz_blank;
  logic [6:0]    seg_hi;
  logic          dp_hi;
  logic [5:0]    an_hi;

  assign scan_wrap   = (scan_cnt == SCAN_LAST);
  assign frame_wrap  = scan_wrap && (slot == SLOT_HR_MSB);
  assign frame_next  = frame_cnt + FW'(1);
  assign slot_onehot = 6'b000001 << slot;

  // Scan counter and slot index; slot advances once per scan period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= 16'd0;
      slot     <= SLOT_SEC_LSB;
    end else if (scan_wrap) begin
      scan_cnt <= 16'd0;
      slot     <= (slot == SLOT_HR_MSB) ? SLOT_SEC_LSB : slot + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  // Shadow capture at frame boundaries and once right after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_pend <= 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= 4'd0;
    end else begin
      init_pend <= 1'b0;
      if (init_pend || frame_wrap) begin
        shadow[SLOT_SEC_LSB] <= sec_lsb;
        shadow[SLOT_SEC_MSB] <= sec_msb;
        shadow[SLOT_MIN_LSB] <= min_lsb;
        shadow[SLOT_MIN_MSB] <= min_msb;
        shadow[SLOT_HR_LSB]  <= hr_lsb;
        shadow[SLOT_HR_MSB]  <= hr_msb;
      end
    end
  end

  // Frame counting, blink phase and the end-of-frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= frame_wrap;
      if (frame_wrap) begin
        if (frame_next == FRAME_END) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_next;
        end
      end
    end
  end

  // Select the shadowed digit for the current slot
  always_comb begin
    cur_digit = 4'd0;
    case (slot)
      SLOT_SEC_LSB: cur_digit = shadow[SLOT_SEC_LSB];
      SLOT_SEC_MSB: cur_digit = shadow[SLOT_SEC_MSB];
      SLOT_MIN_LSB: cur_digit = shadow[SLOT_MIN_LSB];
      SLOT_MIN_MSB: cur_digit = shadow[SLOT_MIN_MSB];
      SLOT_HR_LSB:  cur_digit = shadow[SLOT_HR_LSB];
      SLOT_HR_MSB:  cur_digit = shadow[SLOT_HR_MSB];
      default:      cur_digit = 4'd0;
    endcase
  end

  bcd_to_seg u_dec (
    .bcd (cur_digit),
    .seg (glyph)
  );

  // Blanking rules and digit enables in active-high form
  always_comb begin
    blink_hit = blink_phase && ((blink_en & slot_onehot) != 6'd0);
    lz_blank  = (slot == SLOT_HR_MSB) && (cur_digit == 4'd0);
    seg_hi    = (blink_hit || lz_blank) ? GLYPH_BLANK : glyph;
    dp_hi     = ((slot == SLOT_MIN_LSB) || (slot == SLOT_HR_LSB)) && !blink_hit;
    an_hi     = (scan_cnt == 16'd0) ? 6'd0 : slot_onehot;
  end

  // Registered pins with output polarity applied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= {7{POL}};
      dp  <= POL;
      an  <= {6{POL}};
    end else begin
      seg <= seg_hi ^ {7{POL}};
      dp  <= dp_hi ^ POL;
      an  <= an_hi ^ {6{POL}};
    end
  end

endmodule

// File: tb/tb_watch_display.sv
// tb/tb_watch_display.sv - self-checking bench for watch_display
module tb_watch_display;

  localparam int SD = 4;
  localparam int BD = 2;
  localparam int FRAME_LEN = SD * 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sec_lsb, sec_msb, min_lsb, min_msb, hr_lsb, hr_msb;
  logic [5:0] blink_en;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frame_done;

  int n_checks = 0;
  int n_errors = 0;

  int k = 0;
  int cap [64][6];
  logic [5:0] be_k = 6'd0;

  watch_display #(.SCAN_DIV(SD), .BLINK_DIV(BD), .ACTIVE_LOW(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sec_lsb    (sec_lsb),
    .sec_msb    (sec_msb),
    .min_lsb    (min_lsb),
    .min_msb    (min_msb),
    .hr_lsb     (hr_lsb),
    .hr_msb     (hr_msb),
    .blink_en   (blink_en),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  // Model: edges since release, digit values latched per frame number, live blink mask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0;
    end else begin
      k = k + 1;
      be_k = blink_en;
      if (k == 1 || (k % FRAME_LEN) == 0) begin
        cap[(k / FRAME_LEN) % 64][0] = int'(sec_lsb);
        cap[(k / FRAME_LEN) % 64][1] = int'(sec_msb);
        cap[(k / FRAME_LEN) % 64][2] = int'(min_lsb);
        cap[(k / FRAME_LEN) % 64][3] = int'(min_msb);
        cap[(k / FRAME_LEN) % 64][4] = int'(hr_lsb);
        cap[(k / FRAME_LEN) % 64][5] = int'(hr_msb);
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin : cmp
    int c, s, f, ph, d;
    logic bb;
    logic [6:0] eseg;
    if (!rst_n || k == 0) begin
      check("rst_an", 32'(an), 32'd0);
      check("rst_seg", 32'(seg), 32'd0);
      check("rst_dp", 32'(dp), 32'd0);
      check("rst_fd", 32'(frame_done), 32'd0);
    end else begin
      c  = (k - 1) % SD;
      s  = ((k - 1) / SD) % 6;
      f  = (k - 1) / FRAME_LEN;
      ph = ((k - 1) / (FRAME_LEN * BD)) % 2;
      d  = cap[f % 64][s];
      bb = (ph == 1) && be_k[s];
      check($sformatf("fd@k%0d", k), 32'(frame_done),
            32'((k >= FRAME_LEN) && (k % FRAME_LEN == 0)));
      check($sformatf("an@k%0d", k), 32'(an), (c == 0) ? 32'd0 : (32'd1 << s));
      if (c != 0) begin
        if (bb || (s == 5 && d == 0)) eseg = 7'd0;
        else eseg = glyph(d);
        check($sformatf("seg@k%0d", k), 32'(seg), 32'(eseg));
        check($sformatf("dp@k%0d", k), 32'(dp), 32'((s == 2 || s == 4) && !bb));
      end
    end
  end

  task automatic wait_k(input int target);
    int guard;
    guard = 0;
    while (k < target && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (k < target) check("wait_k_timeout", 32'(k), 32'(target));
  endtask

  initial begin
    sec_lsb = 4'd6; sec_msb = 4'd5; min_lsb = 4'd4;
    min_msb = 4'd3; hr_lsb = 4'd2; hr_msb = 4'd1;
    blink_en = 6'd0;
    repeat (3) @(negedge clk);
    check("lit_rst_an", 32'(an), 32'd0);
    check("lit_rst_seg", 32'(seg), 32'd0);
    rst_n = 1'b1;

    wait_k(2);
    check("lit_slot0_an", 32'(an), 32'h01);
    check("lit_slot0_seg6", 32'(seg), 32'h7D);
    check("lit_slot0_dp", 32'(dp), 32'd0);
    wait_k(10);
    check("lit_slot2_an", 32'(an), 32'h04);
    check("lit_slot2_seg4", 32'(seg), 32'h66);
    check("lit_slot2_dp", 32'(dp), 32'd1);
    wait_k(24);
    check("lit_fd24", 32'(frame_done), 32'd1);
    wait_k(25);
    check("lit_fd25", 32'(frame_done), 32'd0);
    sec_lsb = 4'd7;
    blink_en = 6'b000011;
    wait_k(27);
    check("lit_old_sec", 32'(seg), 32'h7D);
    wait_k(50);
    check("lit_blink_an", 32'(an), 32'h01);
    check("lit_blink_seg", 32'(seg), 32'h00);
    wait_k(58);
    check("lit_noblink_seg", 32'(seg), 32'h66);
    check("lit_noblink_dp", 32'(dp), 32'd1);
    wait_k(98);
    check("lit_new_sec", 32'(seg), 32'h07);
    hr_msb = 4'd0;
    hr_lsb = 4'd12;
    wait_k(138);
    check("lit_dash_an", 32'(an), 32'h10);
    check("lit_dash_seg", 32'(seg), 32'h40);
    wait_k(142);
    check("lit_lz_an", 32'(an), 32'h20);
    check("lit_lz_seg", 32'(seg), 32'h00);
    wait_k(158);
    check("lit_slot3_an", 32'(an), 32'h08);
    #2 rst_n = 1'b0;
    #1;
    check("lit_async_an", 32'(an), 32'd0);
    check("lit_async_seg", 32'(seg), 32'd0);
    check("lit_async_dp", 32'(dp), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_k(1);
    check("lit_rel1_an", 32'(an), 32'd0);
    wait_k(2);
    check("lit_rel2_an", 32'(an), 32'h01);
    check("lit_rel2_seg", 32'(seg), 32'h07);
    wait_k(23);
    check("lit_rel_fd23", 32'(frame_done), 32'd0);
    wait_k(24);
    check("lit_rel_fd24", 32'(frame_done), 32'd1);
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
